// File: rtl/aes_key_expander.sv
// aes_key_expander: word-serial AES-128/192/256 key schedule engine feeding a multi-slot round-key RAM
// Ports: clk, reset (async, active-high); start/mode/slot/key job request, accepted when start && ready;
//        ready/busy engine status; rk_we/rk_addr/rk_data round-key RAM write port ({slot, round});
//        done/err one-cycle completion/rejection pulses; slot_valid per-slot complete-schedule flags.
// Build option: AES_KEYEXP_AES192_EN enables mode 01 (AES-192); otherwise mode 01 is rejected as illegal.
module aes_key_expander #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [SLOT_W-1:0]    slot,
    input  logic [255:0]         key,
    output logic                 ready,
    output logic                 busy,
    output logic                 rk_we,
    output logic [SLOT_W+3:0]    rk_addr,
    output logic [127:0]         rk_data,
    output logic                 done,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] slot_valid
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [255:0]          key_q, key_d;
    logic [5:0]            i_q, i_d;
    logic [2:0]            m_q, m_d;
    logic [7:0]            rcon_q, rcon_d;
    logic [7:0][31:0]      hist_q, hist_d;
    logic                  rk_we_q, rk_we_d;
    logic [SLOT_W+3:0]     rk_addr_q, rk_addr_d;
    logic [127:0]          rk_data_q, rk_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [NUM_SLOTS-1:0]  sv_q, sv_d;

    logic                  legal_mode, legal, key_phase;
    logic [2:0]            nk_last;
    logic [5:0]            last_i;
    logic [31:0]           prev, back, sub_in, sub_out, t, w;

`ifdef AES_KEYEXP_AES192_EN
    assign legal_mode = mode != 2'b11;
    assign nk_last    = mode_q == 2'b10 ? 3'd7 : mode_q == 2'b01 ? 3'd5 : 3'd3;
    assign last_i     = mode_q == 2'b10 ? 6'd59 : mode_q == 2'b01 ? 6'd51 : 6'd43;
    assign back       = mode_q == 2'b10 ? hist_q[7] : mode_q == 2'b01 ? hist_q[5] : hist_q[3];
`else
    assign legal_mode = mode == 2'b00 || mode == 2'b10;
    assign nk_last    = mode_q == 2'b10 ? 3'd7 : 3'd3;
    assign last_i     = mode_q == 2'b10 ? 6'd59 : 6'd43;
    assign back       = mode_q == 2'b10 ? hist_q[7] : hist_q[3];
`endif

    assign legal     = legal_mode && (32'(slot) < NUM_SLOTS);
    assign key_phase = i_q <= {3'd0, nk_last};
    assign prev      = hist_q[0];
    // Byte 0 sits in the low bits, so RotWord is a rotate right by one byte.
    assign sub_in    = m_q == 3'd0 ? {prev[7:0], prev[31:8]} : prev;
    assign sub_out   = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
    assign t         = m_q == 3'd0 ? sub_out ^ {24'd0, rcon_q}
                     : (mode_q == 2'b10 && m_q == 3'd4) ? sub_out : prev;
    assign w         = key_phase ? key_q[{i_q[2:0], 5'd0} +: 32] : back ^ t;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        slot_d    = slot_q;
        key_d     = key_q;
        i_d       = i_q;
        m_d       = m_q;
        rcon_d    = rcon_q;
        hist_d    = hist_q;
        rk_we_d   = 1'b0;
        rk_addr_d = rk_addr_q;
        rk_data_d = rk_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sv_d      = sv_q;
        if (state_q == IDLE) begin
            if (start && legal) begin
                state_d    = RUN;
                mode_d     = mode;
                slot_d     = slot;
                key_d      = key;
                i_d        = 6'd0;
                m_d        = 3'd0;
                rcon_d     = 8'h01;
                sv_d[slot] = 1'b0;
            end else if (start) begin
                err_d = 1'b1;
            end
        end else begin
            hist_d = {hist_q[6:0], w};
            i_d    = i_q + 6'd1;
            m_d    = m_q == nk_last ? 3'd0 : m_q + 3'd1;
            if (m_q == 3'd0 && !key_phase)
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            // Every fourth word completes a round key; the newest word is still combinational.
            if (i_q[1:0] == 2'd3) begin
                rk_we_d   = 1'b1;
                rk_addr_d = {slot_q, i_q[5:2]};
                rk_data_d = {w, hist_q[0], hist_q[1], hist_q[2]};
            end
            if (i_q == last_i) begin
                state_d      = IDLE;
                done_d       = 1'b1;
                sv_d[slot_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 2'b00;
            slot_q    <= '0;
            key_q     <= '0;
            i_q       <= '0;
            m_q       <= '0;
            rcon_q    <= '0;
            hist_q    <= '0;
            rk_we_q   <= 1'b0;
            rk_addr_q <= '0;
            rk_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sv_q      <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            slot_q    <= slot_d;
            key_q     <= key_d;
            i_q       <= i_d;
            m_q       <= m_d;
            rcon_q    <= rcon_d;
            hist_q    <= hist_d;
            rk_we_q   <= rk_we_d;
            rk_addr_q <= rk_addr_d;
            rk_data_q <= rk_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sv_q      <= sv_d;
        end
    end

    assign ready      = state_q == IDLE;
    assign busy       = state_q == RUN;
    assign rk_we      = rk_we_q;
    assign rk_addr    = rk_addr_q;
    assign rk_data    = rk_data_q;
    assign done       = done_q;
    assign err        = err_q;
    assign slot_valid = sv_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: randomized and FIPS-197 vector bench for aes_key_expander against a behavioural key schedule
module tb_aes_key_expander;
    localparam int NS = 3;
    localparam int SW = 2;
`ifdef AES_KEYEXP_AES192_EN
    localparam bit EN192 = 1'b1;
`else
    localparam bit EN192 = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [SW-1:0] slot;
    logic [255:0]  key;
    logic          ready, busy, rk_we, done, err;
    logic [SW+3:0] rk_addr;
    logic [127:0]  rk_data;
    logic [NS-1:0] slot_valid;

    int            n_vec = 0;
    int            n_err = 0;
    logic [NS-1:0] sv_exp = '0;
    logic [31:0]   rw [60];
    logic [7:0]    sb [256];
    logic [127:0]  last;

    always #5 clk = ~clk;

    aes_key_expander #(.NUM_SLOTS(NS)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .slot(slot), .key(key),
        .ready(ready), .busy(busy), .rk_we(rk_we), .rk_addr(rk_addr), .rk_data(rk_data),
        .done(done), .err(err), .slot_valid(slot_valid)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] x = {b, b} << n;
        return x[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'd0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'd1) inv = 8'(y);
            sb[x] = 8'h63 ^ inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4);
        end
    endtask

    function automatic logic [31:0] bsw(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Schedule kept in FIPS-197 big-endian word notation; converted to port packing on compare.
    task automatic expand(input int nk, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) rw[i] = bsw(k[32*i +: 32]);
            else begin
                t = rw[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'd0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) t = subw(t);
                rw[i] = rw[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] rk_of(input int r);
        return {bsw(rw[4*r+3]), bsw(rw[4*r+2]), bsw(rw[4*r+1]), bsw(rw[4*r])};
    endfunction

    function automatic logic [255:0] fkey(input logic [255:0] f);
        logic [255:0] o;
        for (int j = 0; j < 8; j++) o[32*j +: 32] = bsw(f[255-32*j -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] fk(input logic [127:0] f);
        logic [127:0] o;
        for (int j = 0; j < 4; j++) o[32*j +: 32] = bsw(f[127-32*j -: 32]);
        return o;
    endfunction

    // stim: 0 = single-cycle start, 1 = hold start high through the job, 2 = random start noise while busy
    task automatic run_job(input logic [1:0] md, input logic [SW-1:0] sl, input logic [255:0] k,
                           input int stim, output logic [127:0] lst);
        int   nk, n, wr;
        logic ok;
        ok  = (md == 2'd0 || md == 2'd2 || (EN192 && md == 2'd1)) && (32'(sl) < NS);
        lst = '0;
        @(negedge clk);
        start = 1'b1; mode = md; slot = sl; key = k;
        @(posedge clk); #1;
        if (stim != 1) start = 1'b0;
        if (!ok) begin
            check("err_pulse", err, 1);
            check("rej_ready", ready, 1);
            check("rej_we", rk_we, 0);
            check("rej_sv", slot_valid, sv_exp);
            @(posedge clk); #1;
            check("err_clear", err, 0);
            check("rej_we2", rk_we, 0);
            check("rej_ready2", ready, 1);
            check("rej_sv2", slot_valid, sv_exp);
            return;
        end
        nk = md == 2'd0 ? 4 : md == 2'd1 ? 6 : 8;
        n  = 4 * (nk + 7);
        expand(nk, k);
        sv_exp[sl] = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_ready", ready, 0);
        check("acc_sv", slot_valid, sv_exp);
        wr = 0;
        for (int e = 1; e <= n; e++) begin
            if (stim == 2) begin
                start = 1'($urandom);
                mode  = 2'($urandom);
                slot  = SW'($urandom);
                key   = {8{32'($urandom)}};
            end
            @(posedge clk); #1;
            check("we", rk_we, e % 4 == 0);
            check("done", done, e == n);
            check("busy", busy, e < n);
            check("no_err", err, 0);
            if (rk_we) begin
                wr++;
                check("addr", rk_addr, {sl, 4'(e / 4 - 1)});
                check("data", rk_data, rk_of(e / 4 - 1));
                lst = rk_data;
            end
        end
        if (stim != 1) start = 1'b0;
        sv_exp[sl] = 1'b1;
        check("writes", wr, nk + 7);
        check("end_sv", slot_valid, sv_exp);
        check("end_ready", ready, 1);
    endtask

    initial begin
        init_sbox();
        reset = 1'b1; start = 1'b0; mode = 2'd0; slot = '0; key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_we", rk_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", rk_addr, 0);
        check("rst_data", rk_data, 0);
        check("rst_sv", slot_valid, 0);
        @(negedge clk) reset = 1'b0;

        run_job(2'd0, 2'd0, fkey({128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'd0}), 0, last);
        check("a1_r10", last, fk(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));
        check("a1_sv", slot_valid, 3'b001);

        run_job(2'd1, 2'd1, fkey({192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'd0}), 0, last);
        check("a2_r12", last, EN192 ? fk(128'he98ba06f_448c773c_8ecc7204_01002202) : 128'd0);

        run_job(2'd2, 2'd2, fkey(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4), 1, last);
        check("a3_r14", last, fk(128'hfe4890d1_e6188d0b_046df344_706c631e));
        run_job(2'd2, 2'd2, fkey(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4), 0, last);
        check("a3_again", last, fk(128'hfe4890d1_e6188d0b_046df344_706c631e));

        run_job(2'd3, 2'd0, {8{32'($urandom)}}, 0, last);
        run_job(2'd1, 2'd0, {8{32'($urandom)}}, 0, last);
        run_job(2'd0, 2'd3, {8{32'($urandom)}}, 0, last);

        for (int j = 0; j < 8; j++)
            run_job(2'($urandom), SW'($urandom), {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                    32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)}, ($urandom % 2) * 2, last);

        run_job(2'd0, 2'd1, {8{32'($urandom)}}, 0, last);
        @(negedge clk);
        start = 1'b1; mode = 2'd0; slot = 2'd0; key = {8{32'($urandom)}};
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("e20_we", rk_we, 1);
        reset = 1'b1;
        #1;
        sv_exp = '0;
        check("abort_we", rk_we, 0);
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_addr", rk_addr, 0);
        check("abort_data", rk_data, 0);
        check("abort_sv", slot_valid, sv_exp);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            check("post_rst_we", rk_we, 0);
        end
        check("post_rst_ready", ready, 1);
        check("post_rst_sv", slot_valid, sv_exp);

        run_job(2'd0, 2'd1, {8{32'($urandom)}}, 0, last);
        run_job(2'd0, 2'd0, {8{32'($urandom)}}, 2, last);
        run_job(2'd2, 2'd0, {8{32'($urandom)}}, 2, last);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Word-serial AES key schedule engine for AES-128, AES-192 and AES-256. It expands one cipher key per job into Nr+1 128-bit round keys and writes them into a multi-slot round-key RAM, one slot per key context. It sits between the key-loading control path and the round-key RAM read by the encrypt/decrypt cores. It computes one 32-bit schedule word per cycle, which makes key sizes whose length is not a multiple of 128 bits (AES-192) straightforward.

## Interface
Parameters:
- NUM_SLOTS, 2, number of key contexts in the round-key RAM (1..16)
- SLOT_W, $clog2(NUM_SLOTS) (minimum 1), width of the slot index

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted on a rising edge when start && ready
- mode  in  2  key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal
- slot  in  SLOT_W  destination key context
- key  in  256  cipher key; word k = key[32k +: 32], byte 0 of each word at bits [7:0]; unused upper words are ignored
- ready  out  1  engine idle; equals !busy
- busy  out  1  job in progress
- rk_we  out  1  round-key write strobe
- rk_addr  out  SLOT_W+4  {slot, round index r}
- rk_data  out  128  round key r = {w[4r+3], w[4r+2], w[4r+1], w[4r]}
- done  out  1  one-cycle pulse; job complete
- err  out  1  one-cycle pulse; request rejected
- slot_valid  out  NUM_SLOTS  per-slot flag: slot holds a complete schedule

## Operation
- Nk = 4, 6 or 8; Nr = 10, 12 or 14; total words N = 4(Nr+1) = 44, 52 or 60.
- On acceptance, the engine latches mode, slot and key, clears word counter i and clears slot_valid[slot].
- For each word i:
  - If i < Nk, w[i] = key word i.
  - Otherwise t = w[i-1].
  - If i mod Nk == 0: t = SubWord(RotWord(t)), then byte 0 ^= Rcon.
  - If Nk == 8 and i mod 8 == 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
- RotWord in this packing is a rotate right by 8 bits: {b0, b3, b2, b1}.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. It advances on each i mod Nk == 0 word. Track i mod Nk with a wrap counter; no divider.
- The last 8 words are held in a shift history, giving w[i-1] and w[i-Nk].
- One shared SubWord (4 S-boxes).
- A 4-word assembly register feeds rk_data.
- States and transitions:
  - IDLE -> RUN on an accepted, legal request.
  - RUN -> IDLE after word N-1.
- Illegal request (mode 11, or slot >= NUM_SLOTS): err pulses for one cycle, nothing is written, slot_valid is unchanged, and the engine stays IDLE.
- On done, slot_valid[slot] is set.
- start is ignored while busy.

## Timing
- Reset values: ready = 1; busy, rk_we, done and err = 0; rk_addr and rk_data = 0; slot_valid = all zeros. The engine enters IDLE.
- Let the acceptance edge be E0. Word i is registered at edge E(i+1).
- rk_we is registered at E(4r+4). It is high for exactly one cycle, with rk_addr = {slot, r} and rk_data valid in the same cycle.
- Writes occur every 4 cycles, Nr+1 writes in total. The last write is at E(4Nr+4): E44, E52 or E60.
- done pulses coincident with the last rk_we. busy falls and ready rises at the same edge.
- The next start can be accepted at E(4Nr+5), giving a minimum job period of 45, 53 or 61 cycles.
- err is registered at the edge that sampled the illegal request.
- Reset asserted mid-job:
  - Outputs clear immediately and no further writes occur.
  - The target slot's RAM contents are undefined, and its slot_valid flag stays 0.
- slot_valid of other slots is unaffected by a job.

## Configuration
- AES_KEYEXP_AES192_EN defined:
  - mode 01 is legal.
  - The Nk = 6 wrap counter and history tap are built.
- Not defined:
  - mode 01 is treated as illegal (err pulse, no writes).
  - Only the Nk = 4 and Nk = 8 history taps are built.

## Test plan
- AES-128, FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, slot 0:
  - Exactly 11 rk_we pulses at E4, E8, …, E44.
  - addr 10 data words d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - done at E44, slot_valid = 01.
- AES-192, A.2 key 8e73b0f7 … 522c6b7b, slot 1 (macro on):
  - 13 writes.
  - addr {1, 12} words e98ba06f 448c773c 8ecc7204 01002202.
  - done at E52.
- AES-256, A.3 key 603deb10 … 0914dff4:
  - 15 writes.
  - addr 14 words fe4890d1 e6188d0b 046df344 706c631e.
  - done at E60.
  - A second start held high is accepted at E61.
- mode 11, then mode 01 with the macro off, then slot 2 with NUM_SLOTS = 2:
  - Each gives a single err pulse with no rk_we.
  - ready stays 1 and slot_valid is unchanged.
- Re-key slot 0 while slot 1 is valid, with reset asserted at E20:
  - After E20, no rk_we.
  - ready = 1 and slot_valid = 00.
- After completion, start on slot 0:
  - slot_valid[0] clears at acceptance and sets again at done.
  - start pulses while busy are ignored.
